// File: rtl/sha2_pkg.sv
// Shared encodings and constants for the SHA-2 round sequencer.
// Round-index width and message-word count are fixed by the SHA-2 family.
package sha2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;
    localparam int MSG_WORDS  = 16;
    localparam int IDX_W      = 7;

    // Rounds 0..15 consume message words directly; later rounds use the schedule.
    function automatic logic is_msg_round(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(MSG_WORDS);
    endfunction

endpackage

// File: rtl/sha2_round_sequencer_if.sv
// Block handshake, datapath strobes and digest handshake of the round sequencer.
// The slave side is the sequencer; the master side is the datapath/host.
interface sha2_round_sequencer_if
    import sha2_pkg::*;
#(
    parameter int CNTW = 32
);

    logic             blk_valid;
    logic             blk_first;
    logic             blk_last;
    logic             blk_ready;
    logic             abort;
    logic             init_sel;
    logic             load_state;
    logic             round_en;
    logic [IDX_W-1:0] round_idx;
    logic             w_from_msg;
    logic             hash_add;
    logic             digest_valid;
    logic             digest_ready;
    logic [CNTW-1:0]  blk_count;

    modport slave (
        input  blk_valid, blk_first, blk_last, abort, digest_ready,
        output blk_ready, init_sel, load_state, round_en, round_idx,
               w_from_msg, hash_add, digest_valid, blk_count
    );

    modport master (
        output blk_valid, blk_first, blk_last, abort, digest_ready,
        input  blk_ready, init_sel, load_state, round_en, round_idx,
               w_from_msg, hash_add, digest_valid, blk_count
    );

endinterface

// File: rtl/sha2_round_ctr.sv
// Round index counter: synchronous clear has priority over enable.
// The terminal flag marks the last compression round of a block.
module sha2_round_ctr
    import sha2_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             term
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

    assign term = (idx == IDX_W'(ROUNDS - 1));

endmodule

// File: rtl/sha2_round_sequencer.sv
// Control FSM for a one-round-per-clock SHA-2 compression datapath.
// All outputs are decoded from registered state; the sequencer holds no message data.
module sha2_round_sequencer
    import sha2_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int ROUNDS   = ROUNDS_256,
    parameter int CNTW     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    sha2_round_sequencer_if.slave  bus
);

    state_t           state;
    state_t           state_nx;
    logic             first_q;
    logic             last_q;
    logic             armed;
    logic [CNTW-1:0]  cnt;
    logic             accept;
    logic             ctr_clr;
    logic             ctr_en;
    logic             cnt_inc;
    logic             term;
    logic [IDX_W-1:0] idx;

    sha2_round_ctr #(
        .ROUNDS (ROUNDS)
    ) u_round_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .idx  (idx),
        .term (term)
    );

    // armed keeps blk_ready low until the first edge after reset release.
    assign accept = (state == ST_IDLE) && armed && bus.blk_valid && !bus.abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (accept) begin
                first_q <= bus.blk_first;
                last_q  <= bus.blk_last;
            end
            if (accept && bus.blk_first) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ctr_clr  = 1'b1;
        ctr_en   = 1'b0;
        cnt_inc  = 1'b0;
        if (bus.abort) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_nx = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_nx = ST_ROUND;
                end
                ST_ROUND: begin
                    if (term) begin
                        state_nx = ST_ADD;
                    end else begin
                        ctr_clr = 1'b0;
                        ctr_en  = 1'b1;
                    end
                end
                ST_ADD: begin
                    cnt_inc  = 1'b1;
                    state_nx = last_q ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    if (bus.digest_ready) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.blk_ready    = (state == ST_IDLE) && armed;
    assign bus.load_state   = (state == ST_LOAD);
    assign bus.round_en     = (state == ST_ROUND);
    assign bus.hash_add     = (state == ST_ADD);
    assign bus.digest_valid = (state == ST_DONE);
    assign bus.init_sel     = first_q && ((state == ST_LOAD) || (state == ST_ADD));
    assign bus.round_idx    = idx;
    assign bus.w_from_msg   = (state == ST_ROUND) && is_msg_round(idx);
    assign bus.blk_count    = cnt;

    // Round count must match the word size's SHA-2 variant.
    rounds_match_ws: assert property (@(posedge clk) disable iff (!rst)
        ((WORDSIZE == 64) ? (ROUNDS == ROUNDS_512) : (ROUNDS == ROUNDS_256)));

endmodule

// File: tb/tb_sha2_round_sequencer.sv
// Bench for sha2_round_sequencer: instance 0 is SHA-256 (64 rounds, 32-bit count),
// instance 1 is SHA-512 (80 rounds, 2-bit count to exercise wrap).
module tb_sha2_round_sequencer;
    import sha2_pkg::*;

    typedef struct { int g; int kind; int cyc; int idx; bit init; } ev_t;
    typedef struct { int g; int cyc; int unsigned cnt; } dg_t;

    ev_t evq[$];
    dg_t dgq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int unsigned model_cnt[2];

    logic clk;
    logic rst[2];
    logic blk_valid[2], blk_first[2], blk_last[2], abort[2], digest_ready[2];
    logic blk_ready[2], init_sel[2], load_state[2], round_en[2];
    logic w_from_msg[2], hash_add[2], digest_valid[2];
    logic [6:0]  round_idx[2];
    logic [31:0] blk_count[2];
    logic dv_prev[2];

    function automatic int rounds_of(input int g);
        return (g == 0) ? 64 : 80;
    endfunction

    function automatic int unsigned mask_of(input int g);
        return (g == 0) ? 32'hFFFF_FFFF : 32'h3;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int RR = (g == 0) ? 64 : 80;
        localparam int CW = (g == 0) ? 32 : 2;
        localparam int WS = (g == 0) ? 32 : 64;

        sha2_round_sequencer_if #(.CNTW(CW)) bus ();

        assign bus.blk_valid    = blk_valid[g];
        assign bus.blk_first    = blk_first[g];
        assign bus.blk_last     = blk_last[g];
        assign bus.abort        = abort[g];
        assign bus.digest_ready = digest_ready[g];
        assign blk_ready[g]     = bus.blk_ready;
        assign init_sel[g]      = bus.init_sel;
        assign load_state[g]    = bus.load_state;
        assign round_en[g]      = bus.round_en;
        assign round_idx[g]     = bus.round_idx;
        assign w_from_msg[g]    = bus.w_from_msg;
        assign hash_add[g]      = bus.hash_add;
        assign digest_valid[g]  = bus.digest_valid;
        assign blk_count[g]     = 32'(bus.blk_count);

        sha2_round_sequencer #(
            .WORDSIZE (WS),
            .ROUNDS   (RR),
            .CNTW     (CW)
        ) dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus.slave)
        );

        // Scoreboard monitor: every strobe and every digest rise must match a queued expectation.
        always @(negedge clk) begin : mon
            ev_t  e;
            dg_t  d;
            int   obs_kind;
            int   nstrobe;
            logic exp_w;
            nstrobe = int'(load_state[g]) + int'(round_en[g]) + int'(hash_add[g]);
            if (nstrobe != 0) begin
                checks++;
                if (nstrobe != 1) begin
                    errors++;
                    $display("FAIL strobe_exclusive inst=%0d cyc=%0d: %0d strobes active, want 1", g, cyc, nstrobe);
                end
                obs_kind = load_state[g] ? 0 : (round_en[g] ? 1 : 2);
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe inst=%0d cyc=%0d: got kind=%0d idx=%0d, want none", g, cyc, obs_kind, round_idx[g]);
                end else begin
                    e = evq.pop_front();
                    exp_w = (e.kind == 1) && (e.idx < 16);
                    if (e.g != g || obs_kind != e.kind || cyc != e.cyc ||
                        (e.kind == 1 && int'(round_idx[g]) != e.idx) ||
                        init_sel[g] !== e.init || w_from_msg[g] !== exp_w) begin
                        errors++;
                        $display("FAIL strobe inst=%0d: got kind=%0d cyc=%0d idx=%0d init=%b wmsg=%b, want inst=%0d kind=%0d cyc=%0d idx=%0d init=%b wmsg=%b",
                                 g, obs_kind, cyc, round_idx[g], init_sel[g], w_from_msg[g],
                                 e.g, e.kind, e.cyc, e.idx, e.init, exp_w);
                    end
                end
            end
            if (digest_valid[g] === 1'b1 && dv_prev[g] === 1'b0) begin
                checks++;
                if (dgq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digest inst=%0d cyc=%0d: digest_valid rose, want no digest", g, cyc);
                end else begin
                    d = dgq.pop_front();
                    if (d.g != g || cyc != d.cyc || blk_count[g] !== d.cnt) begin
                        errors++;
                        $display("FAIL digest inst=%0d: got cyc=%0d cnt=%0d, want inst=%0d cyc=%0d cnt=%0d",
                                 g, cyc, blk_count[g], d.g, d.cyc, d.cnt);
                    end
                end
            end
            dv_prev[g] <= digest_valid[g];
        end
    end

    // mode 0: full block; mode 1: abort at round stop_at; mode 2: async reset at round stop_at.
    task automatic send_block(input int g, input bit first, input bit last,
                              input int stop_at, input int mode, output int acc);
        int n;
        int r;
        int nr;
        r = rounds_of(g);
        @(negedge clk);
        blk_valid[g] = 1'b1;
        blk_first[g] = first;
        blk_last[g]  = last;
        n = 0;
        while (blk_ready[g] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (blk_ready[g] !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout inst=%0d: blk_ready=%b, want 1 within 500 cycles", g, blk_ready[g]);
            blk_valid[g] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (first) model_cnt[g] = 0;
        evq.push_back('{g: g, kind: 0, cyc: acc, idx: 0, init: first});
        nr = (mode == 0) ? r : stop_at + 1;
        for (int t = 0; t < nr; t++)
            evq.push_back('{g: g, kind: 1, cyc: acc + 1 + t, idx: t, init: 1'b0});
        if (mode == 0) begin
            evq.push_back('{g: g, kind: 2, cyc: acc + r + 1, idx: 0, init: first});
            model_cnt[g] = (model_cnt[g] + 1) & mask_of(g);
            if (last) dgq.push_back('{g: g, cyc: acc + r + 2, cnt: model_cnt[g]});
        end
        @(negedge clk);
        blk_valid[g] = 1'b0;
        blk_first[g] = 1'b0;
        blk_last[g]  = 1'b0;
        if (mode != 0) begin
            n = 0;
            while (!(round_en[g] === 1'b1 && int'(round_idx[g]) == stop_at) && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!(round_en[g] === 1'b1 && int'(round_idx[g]) == stop_at)) begin
                errors++;
                $display("FAIL stop_point inst=%0d: round_idx=%0d round_en=%b, want idx %0d", g, round_idx[g], round_en[g], stop_at);
                return;
            end
            if (mode == 1) begin
                abort[g] = 1'b1;
                @(negedge clk);
                abort[g] = 1'b0;
                checks++;
                if (blk_ready[g] !== 1'b1 || round_en[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_to_idle inst=%0d: blk_ready=%b round_en=%b, want 1 0", g, blk_ready[g], round_en[g]);
                end
            end else begin
                #2 rst[g] = 1'b0;
                #1;
                checks++;
                if ({load_state[g], round_en[g], hash_add[g], init_sel[g], w_from_msg[g],
                     digest_valid[g], blk_ready[g], round_idx[g], blk_count[g]} !== '0) begin
                    errors++;
                    $display("FAIL async_reset inst=%0d: idx=%0d cnt=%0d round_en=%b blk_ready=%b, want all 0",
                             g, round_idx[g], blk_count[g], round_en[g], blk_ready[g]);
                end
                model_cnt[g] = 0;
                @(negedge clk);
                rst[g] = 1'b1;
                #1;
                checks++;
                if (blk_ready[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_release inst=%0d: blk_ready=%b, want 0", g, blk_ready[g]);
                end
            end
        end
    endtask

    task automatic handle_digest(input int g, input int hold);
        int n;
        n = 0;
        while (digest_valid[g] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (digest_valid[g] !== 1'b1) begin
            errors++;
            $display("FAIL digest_timeout inst=%0d: digest_valid=%b, want 1 within 300 cycles", g, digest_valid[g]);
            return;
        end
        checks++;
        if (blk_count[g] !== model_cnt[g]) begin
            errors++;
            $display("FAIL blk_count inst=%0d: got %0d, want %0d", g, blk_count[g], model_cnt[g]);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (digest_valid[g] !== 1'b1 || blk_ready[g] !== 1'b0) begin
                errors++;
                $display("FAIL digest_hold inst=%0d cycle %0d: digest_valid=%b blk_ready=%b, want 1 0", g, i, digest_valid[g], blk_ready[g]);
            end
        end
        digest_ready[g] = 1'b1;
        @(negedge clk);
        digest_ready[g] = 1'b0;
        checks++;
        if (digest_valid[g] !== 1'b0 || blk_ready[g] !== 1'b1) begin
            errors++;
            $display("FAIL digest_release inst=%0d: digest_valid=%b blk_ready=%b, want 0 1", g, digest_valid[g], blk_ready[g]);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (evq.size() != 0 || dgq.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d strobes and %0d digests outstanding, want 0 0", name, evq.size(), dgq.size());
            evq.delete();
            dgq.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({load_state[g], round_en[g], hash_add[g], init_sel[g], w_from_msg[g],
                 digest_valid[g], blk_ready[g], round_idx[g], blk_count[g]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d: idx=%0d cnt=%0d blk_ready=%b, want all 0", g, round_idx[g], blk_count[g], blk_ready[g]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (blk_ready[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_ready inst=%0d: blk_ready=%b, want 0", g, blk_ready[g]);
            end
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (blk_ready[g] !== 1'b1) begin
                errors++;
                $display("FAIL idle_ready inst=%0d: blk_ready=%b, want 1", g, blk_ready[g]);
            end
        end
    endtask

    task automatic test_single();
        int a;
        send_block(0, 1'b1, 1'b1, 0, 0, a);
        handle_digest(0, 0);
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        send_block(0, 1'b1, 1'b0, 0, 0, a1);
        send_block(0, 1'b0, 1'b0, 0, 0, a2);
        send_block(0, 1'b0, 1'b1, 0, 0, a3);
        checks++;
        if (a2 - a1 != 67 || a3 - a2 != 67) begin
            errors++;
            $display("FAIL accept_spacing: got %0d %0d, want 67 67", a2 - a1, a3 - a2);
        end
        handle_digest(0, 20);
        check_drained("back_to_back");
    endtask

    task automatic test_abort();
        int a;
        send_block(0, 1'b1, 1'b0, 0, 0, a);
        digest_ready[0] = 1'b1;
        send_block(0, 1'b0, 1'b0, 30, 1, a);
        digest_ready[0] = 1'b0;
        checks++;
        if (blk_count[0] !== 32'd1) begin
            errors++;
            $display("FAIL abort_count: got %0d, want 1", blk_count[0]);
        end
        send_block(0, 1'b0, 1'b0, 63, 1, a);
        checks++;
        if (blk_count[0] !== 32'd1) begin
            errors++;
            $display("FAIL abort_at_add_count: got %0d, want 1", blk_count[0]);
        end
        blk_valid[0] = 1'b1;
        abort[0]     = 1'b1;
        @(negedge clk);
        blk_valid[0] = 1'b0;
        abort[0]     = 1'b0;
        checks++;
        if (blk_ready[0] !== 1'b1 || load_state[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_accept: blk_ready=%b load_state=%b, want 1 0", blk_ready[0], load_state[0]);
        end
        send_block(0, 1'b0, 1'b1, 0, 0, a);
        for (int n = 0; n < 300 && digest_valid[0] !== 1'b1; n++) @(negedge clk);
        abort[0]        = 1'b1;
        digest_ready[0] = 1'b1;
        @(negedge clk);
        abort[0]        = 1'b0;
        digest_ready[0] = 1'b0;
        checks++;
        if (digest_valid[0] !== 1'b0 || blk_ready[0] !== 1'b1 || blk_count[0] !== 32'd2) begin
            errors++;
            $display("FAIL abort_done: digest_valid=%b blk_ready=%b cnt=%0d, want 0 1 2", digest_valid[0], blk_ready[0], blk_count[0]);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        int a;
        send_block(0, 1'b1, 1'b1, 40, 2, a);
        send_block(0, 1'b1, 1'b1, 0, 0, a);
        handle_digest(0, 0);
        check_drained("reset_mid");
    endtask

    task automatic test_rounds80();
        int a;
        send_block(1, 1'b1, 1'b1, 0, 0, a);
        handle_digest(1, 0);
        send_block(1, 1'b1, 1'b0, 0, 0, a);
        send_block(1, 1'b0, 1'b0, 0, 0, a);
        send_block(1, 1'b0, 1'b0, 0, 0, a);
        send_block(1, 1'b0, 1'b1, 0, 0, a);
        handle_digest(1, 0);
        checks++;
        if (blk_count[1] !== 32'd0) begin
            errors++;
            $display("FAIL count_wrap: got %0d, want 0", blk_count[1]);
        end
        check_drained("rounds80");
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g]          = 1'b0;
            blk_valid[g]    = 1'b0;
            blk_first[g]    = 1'b0;
            blk_last[g]     = 1'b0;
            abort[g]        = 1'b0;
            digest_ready[g] = 1'b0;
            model_cnt[g]    = 0;
            dv_prev[g]      = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_rounds80();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
